change_dispenser: RTL
=====================

// Module: change_dispenser
// PURPOSE
//  Outbound end of the bill-payment kiosk's cash path. The payment FSM accepts notes from the
//  customer. This block pays notes back out: it takes a change request, breaks it into notes
//  greedily from largest to smallest, and drives the note-dispense mechanism one note per
//  valid/ack handshake. It keeps a per-denomination inventory and reports any amount it could
//  not pay, or a mechanism jam.
// PARAMETERS
//  CNT_W        8    width of each denomination inventory counter
//  ACK_TIMEOUT  255  max cycles disp_valid may wait for disp_ack before a jam is declared
// PORTS
//  clk           in   1      rising-edge clock; the only clock
//  reset_n       in   1      asynchronous, active-low reset
//  req_valid     in   1      change request strobe; accepted when req_ready=1
//  req_amount    in   16     change to pay, in rupees
//  req_ready     out  1      1 only in IDLE
//  load_en       in   1      inventory write strobe; honoured only in IDLE
//  load_sel      in   3      denomination index: 0=1000 1=500 2=100 3=50 4=20 5=10 6=5 (7 ignored)
//  load_count    in   CNT_W  new note count for load_sel (overwrite, not add)
//  disp_valid    out  1      note request to mechanism; held until disp_ack or timeout
//  disp_denom    out  4      note code: 1000=1000 500=0100 100=0010 50=0001 20=1010 10=0110 5=0000
//  disp_ack      in   1      mechanism confirms one note ejected; sampled only while disp_valid=1
//  done          out  1      1-cycle pulse when a request finishes
//  short_amount  out  16     unpaid remainder, valid from done until next accept
//  jam           out  1      set with done if a timeout ended the request; cleared on next accept
//  busy          out  1      1 in any state other than IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, all inventory counts=0, disp_valid=0,
//   disp_denom=0000, done=0, short_amount=0, jam=0. req_ready=1, busy=0.
//  States: IDLE, SELECT, DISPENSE, FINISH.
//  IDLE: if req_valid=1, latch rem<=req_amount, idx<=0, clear short_amount and jam, go to SELECT.
//   If load_en=1 in the same cycle, the load also takes effect.
//  SELECT: tests one index per cycle.
//   - If rem==0 or idx==7, go to FINISH.
//   - Else if rem>=value[idx] and count[idx]!=0, set disp_valid=1 with the code for idx,
//     clear the timer, go to DISPENSE.
//   - Else idx<=idx+1 and stay in SELECT.
//  DISPENSE: disp_valid and disp_denom stay stable.
//   - On disp_ack=1: rem<=rem-value[idx], count[idx]<=count[idx]-1, disp_valid<=0, go to SELECT.
//     idx is unchanged, so the same denomination is retried.
//   - If the timer reaches ACK_TIMEOUT with no ack: disp_valid<=0, jam<=1, go to FINISH.
//     The note is not debited.
//   - An ack and the timeout in the same cycle count as an ack.
//  FINISH: short_amount<=rem, done=1 for exactly one cycle, back to IDLE.
//  Arithmetic: rem is 16 bits, values are 16-bit constants. rem never underflows because of
//   the >= guard. A remainder of 1..4 (not a multiple of 5) always ends up in short_amount.
//  Inventory: a count never decrements below 0. It changes only by load (IDLE) or ack (DISPENSE).
//   load_en outside IDLE is ignored.
//  req_valid=0 or req_amount=0: an amount of 0 passes IDLE->SELECT->FINISH with short_amount=0.
//   req_valid while busy is ignored, not queued.
//  disp_ack while disp_valid=0 is ignored.
//  Reset mid-request: immediate return to IDLE, inventory cleared, disp_valid dropped the same
//   instant.
//  Latency: accept to first disp_valid is 2 + (number of indices skipped) cycles.
//   Last ack to done is 2 + (number of indices skipped) cycles.
// TESTING
//  1. Load 2 notes each of 1000/500/100/50/20/10/5; request 1785.
//     -> codes 1000,500,100,100,50,20,10,5 in order; done, short_amount=0.
//  2. Load only 100x1 and 10x3; request 180.
//     -> 100,10,10,10 dispensed; short_amount=50, jam=0.
//  3. Request 7 with 5x5 loaded.
//     -> one 5 note; short_amount=2; count[6] drops to 4.
//  4. ACK_TIMEOUT=8, withhold disp_ack.
//     -> disp_valid drops after 8 cycles; done with jam=1; short_amount=request; inventory unchanged.
//  5. Assert load_en and req_valid while busy.
//     -> both ignored; counts and request unchanged; done pulses exactly once.
//  6. reset_n low while disp_valid=1.
//     -> disp_valid=0 immediately; after release: req_ready=1 and all counts=0.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: breaks a change request into notes greedily (largest first), pays them out
// one per valid/ack handshake, tracks per-denomination inventory and reports shortfall or jam.
module change_dispenser #(
    parameter int CNT_W       = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [15:0]      req_amount,
    output logic             req_ready,
    input  logic             load_en,
    input  logic [2:0]       load_sel,
    input  logic [CNT_W-1:0] load_count,
    output logic             disp_valid,
    output logic [3:0]       disp_denom,
    input  logic             disp_ack,
    output logic             done,
    output logic [15:0]      short_amount,
    output logic             jam,
    output logic             busy
);

    localparam int TMR_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_FINISH   = 2'd3
    } state_t;

    function automatic logic [15:0] denom_value(input logic [2:0] idx);
        logic [15:0] v;
        case (idx)
            3'd0:    v = 16'd1000;
            3'd1:    v = 16'd500;
            3'd2:    v = 16'd100;
            3'd3:    v = 16'd50;
            3'd4:    v = 16'd20;
            3'd5:    v = 16'd10;
            3'd6:    v = 16'd5;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] denom_code(input logic [2:0] idx);
        logic [3:0] c;
        case (idx)
            3'd0:    c = 4'b1000;
            3'd1:    c = 4'b0100;
            3'd2:    c = 4'b0010;
            3'd3:    c = 4'b0001;
            3'd4:    c = 4'b1010;
            3'd5:    c = 4'b0110;
            3'd6:    c = 4'b0000;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [15:0]         rem_r;
    logic [2:0]          idx_r;
    logic [TMR_W-1:0]    timer_r;
    // Entry 7 is never loaded, so an index that runs off the table always reads as empty.
    logic [CNT_W-1:0]    count_r [8];

    logic                disp_valid_r;
    logic [3:0]          disp_denom_r;
    logic                done_r;
    logic [15:0]         short_amount_r;
    logic                jam_r;

    logic                disp_valid_nxt_s;
    logic [3:0]          disp_denom_nxt_s;
    logic                done_nxt_s;
    logic [15:0]         short_nxt_s;
    logic                jam_nxt_s;

    logic [15:0]         cur_value_s;
    logic [CNT_W-1:0]    cur_count_s;
    logic                sel_end_s;
    logic                sel_hit_s;
    logic                ack_s;
    logic                timeout_s;

    assign cur_value_s = denom_value(idx_r);
    assign cur_count_s = count_r[idx_r];
    assign sel_end_s   = (rem_r == 16'd0) || (idx_r == 3'd7);
    assign sel_hit_s   = (rem_r >= cur_value_s) && (cur_count_s != {CNT_W{1'b0}});
    assign ack_s       = disp_ack & disp_valid_r;
    assign timeout_s   = (timer_r == TMR_W'(ACK_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; an ack wins over a simultaneous timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (sel_end_s) begin
                    state_nxt_s = ST_FINISH;
                end else if (sel_hit_s) begin
                    state_nxt_s = ST_DISPENSE;
                end else begin
                    state_nxt_s = ST_SELECT;
                end
            end
            ST_DISPENSE: begin
                if (ack_s) begin
                    state_nxt_s = ST_SELECT;
                end else if (timeout_s) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_DISPENSE;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        disp_valid_nxt_s = disp_valid_r;
        disp_denom_nxt_s = disp_denom_r;
        done_nxt_s       = 1'b0;
        short_nxt_s      = short_amount_r;
        jam_nxt_s        = jam_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    short_nxt_s = 16'd0;
                    jam_nxt_s   = 1'b0;
                end else begin
                    short_nxt_s = short_amount_r;
                    jam_nxt_s   = jam_r;
                end
            end
            ST_SELECT: begin
                if (!sel_end_s && sel_hit_s) begin
                    disp_valid_nxt_s = 1'b1;
                    disp_denom_nxt_s = denom_code(idx_r);
                end else begin
                    disp_valid_nxt_s = disp_valid_r;
                    disp_denom_nxt_s = disp_denom_r;
                end
            end
            ST_DISPENSE: begin
                if (ack_s) begin
                    disp_valid_nxt_s = 1'b0;
                end else if (timeout_s) begin
                    disp_valid_nxt_s = 1'b0;
                    jam_nxt_s        = 1'b1;
                end else begin
                    disp_valid_nxt_s = disp_valid_r;
                end
            end
            ST_FINISH: begin
                done_nxt_s  = 1'b1;
                short_nxt_s = rem_r;
            end
            default: begin
                disp_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_valid_r   <= 1'b0;
            disp_denom_r   <= 4'b0000;
            done_r         <= 1'b0;
            short_amount_r <= 16'd0;
            jam_r          <= 1'b0;
        end else begin
            disp_valid_r   <= disp_valid_nxt_s;
            disp_denom_r   <= disp_denom_nxt_s;
            done_r         <= done_nxt_s;
            short_amount_r <= short_nxt_s;
            jam_r          <= jam_nxt_s;
        end
    end

    // Remainder, denomination index, ack timer and note inventory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_r   <= 16'd0;
            idx_r   <= 3'd0;
            timer_r <= {TMR_W{1'b0}};
            for (int i = 0; i < 8; i++) begin
                count_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        rem_r <= req_amount;
                        idx_r <= 3'd0;
                    end
                    if (load_en && (load_sel != 3'd7)) begin
                        count_r[load_sel] <= load_count;
                    end
                end
                ST_SELECT: begin
                    if (sel_end_s) begin
                        idx_r <= idx_r;
                    end else if (sel_hit_s) begin
                        timer_r <= {TMR_W{1'b0}};
                    end else begin
                        idx_r <= idx_r + 3'd1;
                    end
                end
                ST_DISPENSE: begin
                    if (ack_s) begin
                        rem_r <= rem_r - cur_value_s;
                        if (cur_count_s != {CNT_W{1'b0}}) begin
                            count_r[idx_r] <= cur_count_s - CNT_W'(1);
                        end
                    end else if (!timeout_s) begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                ST_FINISH: begin
                    idx_r <= idx_r;
                end
                default: begin
                    idx_r <= 3'd0;
                end
            endcase
        end
    end

    assign req_ready    = (state_r == ST_IDLE);
    assign busy         = (state_r != ST_IDLE);
    assign disp_valid   = disp_valid_r;
    assign disp_denom   = disp_denom_r;
    assign done         = done_r;
    assign short_amount = short_amount_r;
    assign jam          = jam_r;

endmodule
